// File: rtl/keygen_prime_scheduler_pkg.sv
// keygen_prime_scheduler_pkg: shared state/target codes and width helpers for the key-generation scheduler
//   state_e  : scheduler FSM states
//   tgt_e    : target codes (p, q, kappa, none)
//   words()  : number of 16-bit RNG words needed to fill a w-bit candidate
//   tw_of()  : tester word width, the widest of the three targets
package keygen_prime_scheduler_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_FIX, S_TREQ, S_TWAIT, S_ACCEPT, S_STEP, S_DONE, S_FAIL
    } state_e;

    typedef enum logic [1:0] {TGT_P, TGT_Q, TGT_K, TGT_NONE} tgt_e;

    localparam int WORD_W = 16;

    function automatic int words(input int w);
        return w / WORD_W;
    endfunction

    function automatic int tw_of(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/keygen_prime_scheduler_if.sv
// keygen_prime_scheduler_if: RNG stream and Miller-Rabin tester handshake bundle
//   rng_word/rng_valid/rng_ready : 16-bit random word stream into the scheduler
//   mr_start/mr_candidate        : test launch pulse and TW-bit candidate out of the scheduler
//   mr_done/mr_prime             : tester verdict pulse and result back into the scheduler
//   master = scheduler side, slave = RNG/tester side
interface keygen_prime_scheduler_if #(
    parameter int TW = 272
);
    logic [15:0]   rng_word;
    logic          rng_valid;
    logic          rng_ready;
    logic          mr_start;
    logic [TW-1:0] mr_candidate;
    logic          mr_done;
    logic          mr_prime;

    modport master (
        input  rng_word, rng_valid, mr_done, mr_prime,
        output rng_ready, mr_start, mr_candidate
    );

    modport slave (
        output rng_word, rng_valid, mr_done, mr_prime,
        input  rng_ready, mr_start, mr_candidate
    );
endinterface

// File: rtl/keygen_prime_scheduler_candidate_reg.sv
// keygen_prime_scheduler_candidate_reg: TW-bit prime candidate register
//   clk, reset : clock, asynchronous active-high reset
//   load/idx/data : write 16-bit word idx; word 0 also clears the rest so the
//                   candidate stays zero-extended above the target width
//   fix        : set the top bit of the selected width and bit 0
//   inc        : add 2 modulo 2^W (W chosen by sel)
//   sel        : current target, selects W
//   q          : candidate value
//   wrap       : the +2 result has bit W-1 clear (carry out or top bit lost)
module keygen_prime_scheduler_candidate_reg
    import keygen_prime_scheduler_pkg::*;
#(
    parameter int LAMBDA = 272,
    parameter int ETA    = 240,
    parameter int NU     = 16,
    parameter int TW     = 272,
    parameter int IW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [IW-1:0] idx,
    input  logic [15:0]   data,
    input  logic          fix,
    input  logic          inc,
    input  tgt_e          sel,
    output logic [TW-1:0] q,
    output logic          wrap
);
    localparam int MW = (TW > 1) ? $clog2(TW) : 1;
    localparam logic [MW-1:0] MSB_P = MW'(LAMBDA - 1);
    localparam logic [MW-1:0] MSB_Q = MW'(ETA - 1);
    localparam logic [MW-1:0] MSB_K = MW'(NU - 1);

    logic [MW-1:0] msb;
    logic [TW-1:0] mask, sum;

    always_comb begin
        msb  = sel == TGT_P ? MSB_P : sel == TGT_Q ? MSB_Q : MSB_K;
        // 2 << msb overflows to 0 when W == TW, giving an all-ones mask
        mask = (TW'(2) << msb) - TW'(1);
        sum  = (q + TW'(2)) & mask;
        wrap = ~sum[msb];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= (idx == '0 ? '0 : q & ~(TW'(16'hFFFF) << {idx, 4'b0})) | (TW'(data) << {idx, 4'b0});
        else if (fix)
            q <= q | (TW'(1) << msb) | TW'(1);
        else if (inc)
            q <= sum;
    end
endmodule

// File: rtl/keygen_prime_scheduler.sv
// keygen_prime_scheduler: fills p, q and kappa prime candidates from one RNG stream and time-shares one tester
//   clk, reset           : clock, asynchronous active-high reset
//   start                : 1-cycle pulse starting a run (ignored while busy)
//   bus (master)         : RNG word stream in, Miller-Rabin launch/verdict handshake
//   target               : 0 = p, 1 = q, 2 = kappa, 3 = none
//   busy / done / fail   : run in progress / all keys valid / a target ran out of tries
//   p_key, q_param, kappa_key : accepted primes, 0 until accepted
module keygen_prime_scheduler
    import keygen_prime_scheduler_pkg::*;
#(
    parameter int LAMBDA    = 272,
    parameter int ETA       = 240,
    parameter int NU        = 16,
    parameter int MAX_TRIES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    keygen_prime_scheduler_if.master bus,
    output logic [1:0]        target,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [LAMBDA-1:0] p_key,
    output logic [ETA-1:0]    q_param,
    output logic [NU-1:0]     kappa_key
);
    localparam int TW  = tw_of(LAMBDA, ETA, NU);
    localparam int IW  = $clog2(words(TW) + 1);
    localparam int TRW = $clog2(MAX_TRIES + 1);

    state_e         state;
    tgt_e           tgt;
    logic [IW-1:0]  widx, last;
    logic [TRW-1:0] tries;
    logic [TW-1:0]  cand;
    logic           wrap, load, fix, inc, exhausted, rng_ready_r, mr_start_r;

    always_comb begin
        last      = tgt == TGT_P ? IW'(words(LAMBDA) - 1) : tgt == TGT_Q ? IW'(words(ETA) - 1) : IW'(words(NU) - 1);
        load      = state == S_FILL && bus.rng_valid;
        fix       = state == S_FIX;
        inc       = state == S_STEP;
        exhausted = tries == TRW'(MAX_TRIES);
    end

    keygen_prime_scheduler_candidate_reg #(
        .LAMBDA(LAMBDA), .ETA(ETA), .NU(NU), .TW(TW), .IW(IW)
    ) u_cand (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .idx  (widx),
        .data (bus.rng_word),
        .fix  (fix),
        .inc  (inc),
        .sel  (tgt),
        .q    (cand),
        .wrap (wrap)
    );

    assign bus.rng_ready    = rng_ready_r;
    assign bus.mr_start     = mr_start_r;
    assign bus.mr_candidate = cand;
    assign target           = tgt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tgt         <= TGT_NONE;
            widx        <= '0;
            tries       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            rng_ready_r <= 1'b0;
            mr_start_r  <= 1'b0;
            p_key       <= '0;
            q_param     <= '0;
            kappa_key   <= '0;
        end else begin
            mr_start_r <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: if (start) begin
                    state       <= S_FILL;
                    tgt         <= TGT_P;
                    widx        <= '0;
                    tries       <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    fail        <= 1'b0;
                    rng_ready_r <= 1'b1;
                    p_key       <= '0;
                    q_param     <= '0;
                    kappa_key   <= '0;
                end
                S_FILL: if (bus.rng_valid) begin
                    widx <= widx + IW'(1);
                    if (widx == last) begin
                        rng_ready_r <= 1'b0;
                        state       <= S_FIX;
                    end
                end
                S_FIX: begin
                    // mr_start is registered, so it rises as the FSM enters TREQ
                    mr_start_r <= 1'b1;
                    state      <= S_TREQ;
                end
                S_TREQ: begin
                    tries <= tries + TRW'(1);
                    state <= S_TWAIT;
                end
                S_TWAIT: if (bus.mr_done) state <= bus.mr_prime ? S_ACCEPT : S_STEP;
                S_ACCEPT: begin
                    if (tgt == TGT_P) p_key <= cand[LAMBDA-1:0];
                    if (tgt == TGT_Q) q_param <= cand[ETA-1:0];
                    if (tgt == TGT_K) kappa_key <= cand[NU-1:0];
                    tries <= '0;
                    widx  <= '0;
                    if (tgt == TGT_K) begin
                        state <= S_DONE;
                        tgt   <= TGT_NONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= S_FILL;
                        tgt         <= tgt_e'(tgt + 2'd1);
                        rng_ready_r <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (exhausted) begin
                        state <= S_FAIL;
                        tgt   <= TGT_NONE;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                    end else if (wrap) begin
                        // the odd walk left the top of the width: draw a fresh candidate, keep tries
                        state       <= S_FILL;
                        widx        <= '0;
                        rng_ready_r <= 1'b1;
                    end else begin
                        state      <= S_TREQ;
                        mr_start_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keygen_prime_scheduler.sv
// tb_keygen_prime_scheduler: randomized bench for keygen_prime_scheduler against a behavioural candidate model
module tb_keygen_prime_scheduler;
    import keygen_prime_scheduler_pkg::*;

    localparam int LAMBDA    = 272;
    localparam int ETA       = 240;
    localparam int NU        = 16;
    localparam int MAX_TRIES = 4;
    localparam int TW        = 272;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        target;
    logic              busy, done, fail;
    logic [LAMBDA-1:0] p_key;
    logic [ETA-1:0]    q_param;
    logic [NU-1:0]     kappa_key;

    keygen_prime_scheduler_if #(.TW(TW)) bus ();

    keygen_prime_scheduler #(
        .LAMBDA(LAMBDA), .ETA(ETA), .NU(NU), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .target   (target),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .p_key    (p_key),
        .q_param  (q_param),
        .kappa_key(kappa_key)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int consumed = 0;
    int prime_pct = 35;
    logic hold_valid = 1'b0;
    logic [15:0] word_q[$];
    logic        verdict_q[$];

    always @(posedge clk) if (bus.rng_valid && bus.rng_ready) consumed++;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] next_word();
        return word_q.size() != 0 ? word_q.pop_front() : 16'($urandom);
    endfunction

    function automatic logic next_verdict();
        return verdict_q.size() != 0 ? verdict_q.pop_front() : ($urandom_range(0, 99) < prime_pct);
    endfunction

    task automatic feed_word(input logic [15:0] w);
        int n = 0;
        bus.rng_word = w;
        forever begin
            @(negedge clk);
            bus.rng_valid = hold_valid || ($urandom_range(0, 1) == 1);
            bus.mr_done   = !bus.rng_valid && ($urandom_range(0, 3) == 0);
            if (bus.rng_valid && bus.rng_ready) begin
                @(posedge clk);
                #1;
                bus.rng_valid = 1'b0;
                bus.mr_done   = 1'b0;
                return;
            end
            if (++n > 100) begin
                bus.mr_done = 1'b0;
                check("rng_ready timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_mr_start(output bit ok);
        int n = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mr_start) begin
                ok = 1'b1;
                return;
            end
            if (++n > 100) begin
                check("mr_start timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic respond(input logic v);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        start        = 1'b0;
        bus.mr_done  = 1'b1;
        bus.mr_prime = v;
        @(negedge clk);
        bus.mr_done  = 1'b0;
        bus.mr_prime = 1'($urandom_range(0, 1));
    endtask

    task automatic run();
        logic [TW-1:0] key[3];
        logic [TW-1:0] cand, nxt, mask;
        logic [15:0]   wd;
        int w, tries, used, base;
        bit failed, accepted, refill, ok;
        logic v;
        for (int i = 0; i < 3; i++) key[i] = '0;
        failed = 1'b0;
        used   = 0;
        base   = consumed;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start busy", busy, 1);
        check("start done", done, 0);
        check("start fail", fail, 0);
        check("start p_key", p_key, 0);
        for (int t = 0; t < 3 && !failed; t++) begin
            w = t == 0 ? LAMBDA : t == 1 ? ETA : NU;
            mask = '1;
            mask = mask >> (TW - w);
            tries = 0;
            accepted = 1'b0;
            refill = 1'b1;
            while (!accepted && !failed) begin
                if (refill) begin
                    cand = '0;
                    for (int k = 0; k < w / 16; k++) begin
                        wd = next_word();
                        feed_word(wd);
                        used++;
                        cand[16*k +: 16] = wd;
                    end
                    cand[w-1] = 1'b1;
                    cand[0]   = 1'b1;
                end
                wait_mr_start(ok);
                if (!ok) return;
                check("target", target, t);
                check("mr_candidate", bus.mr_candidate, cand);
                tries++;
                v = next_verdict();
                respond(v);
                if (v) begin
                    key[t]   = cand;
                    accepted = 1'b1;
                end else if (tries == MAX_TRIES) begin
                    failed = 1'b1;
                end else begin
                    nxt    = (cand + 2) & mask;
                    refill = nxt < (TW'(1) << (w - 1));
                    cand   = nxt;
                end
            end
        end
        repeat (2) @(negedge clk);
        check("end done", done, !failed);
        check("end fail", fail, failed);
        check("end busy", busy, 0);
        check("end target", target, 3);
        check("p_key", p_key, key[0]);
        check("q_param", q_param, key[1]);
        check("kappa_key", kappa_key, key[2]);
        check("words consumed", consumed - base, used);
    endtask

    task automatic preload_pq_words();
        repeat (words(LAMBDA) + words(ETA)) word_q.push_back(16'($urandom));
    endtask

    initial begin
        int n;
        bus.rng_word  = '0;
        bus.rng_valid = 1'b0;
        bus.mr_done   = 1'b0;
        bus.mr_prime  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset fail", fail, 0);
        check("reset target", target, 3);
        check("reset rng_ready", bus.rng_ready, 0);
        check("reset mr_start", bus.mr_start, 0);
        check("reset kappa", kappa_key, 0);
        reset = 1'b0;

        @(negedge clk);
        bus.rng_valid = 1'b1;
        bus.rng_word  = 16'($urandom);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!bus.mr_start && n < 100);
        check("latency incl. start cycle", n + 1, LAMBDA / 16 + 3);
        bus.rng_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun reset busy", busy, 0);
        check("midrun reset target", target, 3);
        check("midrun reset candidate", bus.mr_candidate, 0);
        check("midrun reset mr_start", bus.mr_start, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.mr_done  = 1'b1;
        bus.mr_prime = 1'b1;
        @(negedge clk);
        bus.mr_done = 1'b0;
        repeat (2) @(negedge clk);
        check("stray done busy", busy, 0);
        check("stray done target", target, 3);
        check("stray done flag", done, 0);
        check("stray done p_key", p_key, 0);

        preload_pq_words();
        word_q.push_back(16'h0010);
        verdict_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run();
        check("kappa walk", kappa_key, 16'h8015);

        preload_pq_words();
        word_q.push_back(16'hFFFE);
        word_q.push_back(16'h4000);
        verdict_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        run();
        check("kappa wrap refill", kappa_key, 16'hC001);

        verdict_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run();
        check("q exhaust fail", fail, 1);
        check("q exhaust q_param", q_param, 0);

        repeat (12) run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
